// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side output stage.
package fifo_pkg;

   // Default data word width.
   localparam int DSIZE_DEF = 8;

   // Memory read latency in rclk cycles (synchronous-read port).
   localparam int RD_LAT = 1;

   // Output buffer depth; the skid buffer and credit logic assume exactly 2.
   localparam int BUF_DEPTH = 2;

   // Word count held in the output buffer (0..2).
   typedef logic [1:0] occ_t;

   // One bit per outstanding memory read.
   typedef logic [RD_LAT-1:0] inflight_t;

   localparam occ_t OCC_FULL = occ_t'(BUF_DEPTH);

   // Buffer operation for one cycle, encoded as {write, read}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RW   = 2'b11
   } skid_op_e;

   // A new pop may be issued while the words stored plus the words on
   // their way from memory, less the word leaving this cycle, leave a slot.
   function automatic logic has_credit(occ_t occ, inflight_t inflight, logic deq);
      logic [2:0] used;
      used = 3'(occ) + 3'(inflight) - 3'(deq);
      return used < 3'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// Read-side bus: pop handshake with the read-pointer block, memory read
// data, and the first-word-fall-through stream to the consumer.
interface fifo_rd_fwft_if
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
);
   logic             rempty;
   logic             rinc;
   logic [DSIZE-1:0] mem_rdata;
   logic             m_valid;
   logic             m_ready;
   logic [DSIZE-1:0] m_data;
   occ_t             m_count;
   logic             ovf_err;

   // The output stage itself.
   modport slave (
      input  rempty, mem_rdata, m_ready,
      output rinc, m_valid, m_data, m_count, ovf_err
   );

   // The surrounding FIFO and consumer.
   modport master (
      output rempty, mem_rdata, m_ready,
      input  rinc, m_valid, m_data, m_count, ovf_err
   );
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry register FIFO: head is always the oldest word, tail is the skid
// slot used only when both entries are occupied.
module fifo_skid2
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             wr_en_i,
   input  logic [DSIZE-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [DSIZE-1:0] head_o,
   output occ_t             occ_o
);

   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   occ_t             occ_q, occ_d;
   logic             do_rd;
   logic             do_wr;
   skid_op_e         op;

   // A read of an empty buffer is ignored; a write into a full buffer is
   // dropped unless a read frees a slot in the same cycle.
   assign do_rd = rd_en_i && (occ_q != 2'd0);
   assign do_wr = wr_en_i && ((occ_q != OCC_FULL) || do_rd);
   assign op    = skid_op_e'({do_wr, do_rd});

   // Next-state for head, tail and occupancy.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      unique case (op)
         OP_WR: begin
            if (occ_q == 2'd0) head_d = wr_data_i;
            else               tail_d = wr_data_i;
            occ_d = occ_q + 2'd1;
         end
         OP_RD: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         OP_RW: begin
            // Head advances and the new word takes the freed slot.
            if (occ_q == 2'd1) begin
               head_d = wr_data_i;
            end else begin
               head_d = tail_q;
               tail_d = wr_data_i;
            end
         end
         default: ;
      endcase
   end

   // Storage and occupancy registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         // NOTE: the data slots are reset too, because the head drives m_data, which must read 0 out of reset.
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_o = head_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side output stage: issues pops against a credit of two words,
// captures the synchronous memory read one cycle later, and presents the
// words as a bubble-free first-word-fall-through valid/ready stream.
module fifo_rd_fwft
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   fifo_rd_fwft_if.slave         rd_if
);

   occ_t             occ;
   logic [DSIZE-1:0] head;
   inflight_t        inflight_q, inflight_d;
   logic             run_q, run_d;
   logic             ovf_q, ovf_d;
   logic             m_valid;
   logic             deq;
   logic             rinc;
   logic             pop_acc;

   assign m_valid = (occ != 2'd0);
   assign deq     = m_valid && rd_if.m_ready;

   // run_q keeps rinc low while in reset and for the first edge after release.
   assign run_d   = 1'b1;
   assign rinc    = run_q && has_credit(occ, inflight_q, deq);

   // The read-pointer block accepts the pop only when not empty; the data
   // for an accepted pop is on mem_rdata during the following cycle.
   assign pop_acc    = rinc && !rd_if.rempty;
   assign inflight_d = inflight_t'(pop_acc);

   // Sticky flag: a word arrived with no free slot. Cannot happen while the
   // credit rule holds.
   assign ovf_d = ovf_q || (inflight_q[0] && (occ == OCC_FULL) && !deq);

   fifo_skid2 #(
      .DSIZE (DSIZE)
   ) u_skid (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .wr_en_i   (inflight_q[0]),
      .wr_data_i (rd_if.mem_rdata),
      .rd_en_i   (deq),
      .head_o    (head),
      .occ_o     (occ)
   );

   // Inflight tracking, post-reset enable and the overflow flag.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         inflight_q <= '0;
         run_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         run_q      <= run_d;
         ovf_q      <= ovf_d;
      end
   end

   assign rd_if.rinc    = rinc;
   assign rd_if.m_valid = m_valid;
   assign rd_if.m_data  = head;
   assign rd_if.m_count = occ;
   assign rd_if.ovf_err = ovf_q;

   // A word must never arrive at a full buffer that is not draining.
   a_no_overflow : assert property (@(posedge rclk) disable iff (!rrst_n)
      !(inflight_q[0] && (occ == OCC_FULL) && !deq));

   // Stored plus outstanding words never exceed the buffer depth.
   a_credit : assert property (@(posedge rclk) disable iff (!rrst_n)
      (3'(occ) + 3'(inflight_q)) <= 3'(BUF_DEPTH));

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
Read-side output stage of the async FIFO, directly downstream of the read-pointer/empty logic and the dual-port memory, in the rclk domain.
- Drives the pop request (rinc) into the read-pointer block.
- Captures words from the synchronous-read memory port (1-cycle latency).
- Presents them to the consumer as a first-word-fall-through valid/ready stream with full throughput and no bubbles.

Parameters:
DSIZE, 8, data word width in bits
BUF_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  asynchronous active-low reset
rempty  input  1  FIFO empty flag from read-pointer block (registered there)
rinc  output  1  pop request to read-pointer block; a pop is accepted when rinc & ~rempty
mem_rdata  input  DSIZE  memory read data; valid the cycle after an accepted pop
m_valid  output  1  output word valid
m_ready  input  1  consumer accepts word when m_valid & m_ready
m_data  output  DSIZE  output word (head of buffer)
m_count  output  2  words held in buffer (0..2)
ovf_err  output  1  sticky: memory word arrived with buffer full (design-error flag)

Behaviour:
- Reset (rrst_n low, async): buffer empty, inflight=0, m_valid=0, m_data=0, m_count=0, ovf_err=0, rinc=0.
- Reset mid-stream: contents are discarded immediately. Any inflight word arriving after release is ignored because inflight=0.
- State per cycle:
  - occ (0..2) = words stored.
  - inflight (0/1) = pop accepted last cycle, data due this cycle.
  - deq = m_valid & m_ready.
- Pop issue (combinational): rinc = (occ + inflight - deq) < 2.
  - rinc is qualified by the read-pointer block with ~rempty; this block also tracks pop_acc = rinc & ~rempty.
  - rinc depends combinationally on m_ready. This path is allowed and ends at registers.
- inflight_next = pop_acc.
- When inflight=1, mem_rdata is written into the buffer tail on the rclk edge.
- Buffer is a 2-entry FIFO (head, tail/skid).
  - m_data always equals head; m_valid = (occ != 0).
  - Simultaneous deq and write: head advances and the new word enters the freed slot. occ is unchanged.
  - Write into an empty buffer: the word becomes head, and m_valid rises the cycle after the data arrives.
  - Overall latency from accepted pop to m_valid: 2 rclk edges (memory read edge + capture edge).
- Throughput: with rempty=0 and m_ready held 1, one word per cycle after a 2-cycle fill, no bubbles.
- Backpressure:
  - With m_ready=0, at most 2 words are stored and rinc drops once occ + inflight = 2.
  - No word is lost or duplicated.
  - m_data and m_valid stay stable while m_valid & ~m_ready (AXI-style hold rule).
- Empty: when rempty=1 no pop is accepted and inflight goes to 0. The buffer drains to m_valid=0.
- ovf_err: set if inflight=1 and occ=2 and deq=0 on an edge. It is unreachable under the credit rule and is checked by assertion. It clears only on reset.
- m_count = occ (registered).

Decomposition:
- Shared package fifo_pkg holds:
  - DSIZE default;
  - read-latency constant RD_LAT=1;
  - buffer-depth constant.
- One natural sub-module, fifo_skid2: a 2-entry register FIFO with wr_en/wr_data, rd_en, head, occ.
  - fifo_rd_fwft adds the credit/inflight logic, rinc generation and ovf_err.

Test Plan:
- Reset then rempty=1 for 10 cycles -> rinc=1 but no pop accepted; m_valid=0, m_count=0, ovf_err=0 throughout.
- Streaming: memory holds 0x01..0x08, rempty=0 until 8 pops, m_ready=1 -> m_data 0x01..0x08 on consecutive cycles, first m_valid 2 cycles after first accepted pop, no gaps.
- Backpressure: stream 0x10..0x17, m_ready=0 from cycle 3 for 6 cycles -> rinc deasserts, m_count=2; m_data holds stable at its current value (m_valid=1, data unchanged) for the whole stall; after release all 8 words arrive in order with no loss or duplication.
- Random m_ready toggle (50%) with rempty toggling, 1000 words -> scoreboard matches exactly; ovf_err never set; occ + inflight <= 2 every cycle.
- Last word: single word 0xA5, rempty rises right after its pop -> m_valid pulses with 0xA5, then m_valid=0 and rinc stays high with no further accepted pops.
- Reset mid-stream: assert rrst_n low while m_count=2 and inflight=1 -> m_valid=0 and m_count=0 immediately; after release the stale mem_rdata is not captured.
